// File: rtl/ro_mon_pkg.sv
// Shared constants for the ring-oscillator degradation monitor: FSM state
// encodings, read-address select decode and a small elaboration helper.
package ro_mon_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StSettle = 3'd1;
    localparam state_t StCount  = 3'd2;
    localparam state_t StStore  = 3'd3;
    localparam state_t StNext   = 3'd4;
    localparam state_t StDone   = 3'd5;

    // Top bit of rd_addr selects which array is read back.
    localparam logic SelResult = 1'b0;
    localparam logic SelBase   = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_mon_if.sv
// Control, oscillator and readout bundle of the degradation monitor.
// Signal suffixes are from the monitor's point of view.
interface ro_mon_if #(
    parameter int unsigned NUM_OSC = 10,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned ADDR_W  = 5
);
    logic               start_i;
    logic               continuous_i;
    logic               clr_base_i;
    logic [WIN_W-1:0]   window_i;
    logic [CNT_W-1:0]   thresh_i;
    logic [NUM_OSC-1:0] osc_i;
    logic [NUM_OSC-1:0] test_en_o;
    logic               stress_o;
    logic               busy_o;
    logic               done_o;
    logic [NUM_OSC-1:0] alarm_o;
    logic [ADDR_W-1:0]  rd_addr_i;
    logic [CNT_W-1:0]   rd_data_o;

    // Controller / RO array / readout side.
    modport master (
        output start_i, continuous_i, clr_base_i, window_i, thresh_i, osc_i, rd_addr_i,
        input  test_en_o, stress_o, busy_o, done_o, alarm_o, rd_data_o
    );

    // Monitor side.
    modport slave (
        input  start_i, continuous_i, clr_base_i, window_i, thresh_i, osc_i, rd_addr_i,
        output test_en_o, stress_o, busy_o, done_o, alarm_o, rd_data_o
    );
endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises every oscillator input, picks the channel under test and
// counts its rising edges into a saturating counter.
module ro_edge_counter #(
    parameter int unsigned NUM_OSC = 10,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_OSC-1:0] osc_i,
    input  logic [IDX_W-1:0]   sel_i,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [CNT_W-1:0]   count_o
);
    logic [NUM_OSC-1:0] sync1_q;
    logic [NUM_OSC-1:0] sync2_q;
    logic               muxed;
    logic               prev_q;
    logic [CNT_W-1:0]   count_q;

    // Two-flop synchroniser on every asynchronous RO output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= osc_i;
            sync2_q <= sync1_q;
        end
    end

    // Select the synchronised channel under test.
    always_comb begin
        muxed = 1'b0;
        for (int unsigned i = 0; i < NUM_OSC; i++) begin
            if (sel_i == IDX_W'(i)) muxed = sync2_q[i];
        end
    end

    // Edge history always tracks the mux so stale edges never count after a switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q <= muxed;
            if (clr_i) begin
                count_q <= '0;
            end else if (en_i && muxed && !prev_q && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ro_degradation_monitor.sv
// Sweeps the RO channels one at a time, measures each over a programmable
// window, keeps a first-measurement baseline per channel and raises sticky
// alarms when a later measurement drops by more than the threshold.
module ro_degradation_monitor
    import ro_mon_pkg::*;
#(
    parameter int unsigned NUM_OSC       = 10,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned ADDR_W        = 5
) (
    input  logic clk,
    input  logic rst,
    ro_mon_if.slave bus
);
    localparam int unsigned IdxW = ADDR_W - 1;
    localparam int unsigned TmrW = max_u(WIN_W, $clog2(SETTLE_CYCLES) + 1);
    localparam logic [TmrW-1:0] SettleLoad = TmrW'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [TmrW-1:0]    tmr_q, tmr_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [TmrW-1:0]    win_load;
    logic               clr_base;
    logic               store;

    logic [CNT_W-1:0]   result_q [NUM_OSC];
    logic [CNT_W-1:0]   base_q   [NUM_OSC];
    logic [NUM_OSC-1:0] base_valid_q;
    logic [NUM_OSC-1:0] alarm_q;
    logic [CNT_W-1:0]   rd_data_q;
    logic [NUM_OSC-1:0] test_en;
    logic [CNT_W-1:0]   count;

    logic               rd_sel;
    logic [IdxW-1:0]    rd_idx;

    assign rd_sel = bus.rd_addr_i[ADDR_W-1];
    assign rd_idx = bus.rd_addr_i[ADDR_W-2:0];

    // A zero window behaves as a one-cycle window.
    assign win_load = (win_q == '0) ? '0 : TmrW'(win_q - WIN_W'(1));

    ro_edge_counter #(
        .NUM_OSC (NUM_OSC),
        .CNT_W   (CNT_W),
        .IDX_W   (IdxW)
    ) u_edge_counter (
        .clk     (clk),
        .rst     (rst),
        .osc_i   (bus.osc_i),
        .sel_i   (idx_q),
        .clr_i   (state_q == StSettle),
        .en_i    (state_q == StCount),
        .count_o (count)
    );

    // Sweep sequencer: phase timer, channel index and latched window/threshold.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        win_d    = win_q;
        thr_d    = thr_q;
        clr_base = 1'b0;
        store    = 1'b0;
        case (state_q)
            StIdle: begin
                clr_base = bus.clr_base_i;
                if (bus.start_i) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    tmr_d   = SettleLoad;
                    win_d   = bus.window_i;
                    thr_d   = bus.thresh_i;
                end
            end
            StSettle: begin
                if (tmr_q == '0) begin
                    state_d = StCount;
                    tmr_d   = win_load;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StCount: begin
                if (tmr_q == '0) begin
                    state_d = StStore;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StStore: begin
                store   = 1'b1;
                state_d = StNext;
            end
            StNext: begin
                if (idx_q == IdxW'(NUM_OSC - 1)) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StSettle;
                    tmr_d   = SettleLoad;
                end
            end
            StDone: begin
                if (bus.continuous_i) begin
                    state_d = StSettle;
                    tmr_d   = SettleLoad;
                    win_d   = bus.window_i;
                    thr_d   = bus.thresh_i;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmr_q   <= '0;
            win_q   <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            thr_q   <= thr_d;
        end
    end

    // Result/baseline capture and alarm compare; the first measurement after a clear becomes
    // the baseline, later ones only compare against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_OSC; i++) begin
                result_q[i] <= '0;
                base_q[i]   <= '0;
            end
            base_valid_q <= '0;
            alarm_q      <= '0;
        end else begin
            if (clr_base) begin
                base_valid_q <= '0;
                alarm_q      <= '0;
            end
            if (store) begin
                for (int unsigned i = 0; i < NUM_OSC; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        result_q[i] <= count;
                        if (!base_valid_q[i]) begin
                            base_q[i]       <= count;
                            base_valid_q[i] <= 1'b1;
                        end else if ((base_q[i] > count) && ((base_q[i] - count) > thr_q)) begin
                            alarm_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Registered read port; indices beyond the array read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= '0;
            for (int unsigned i = 0; i < NUM_OSC; i++) begin
                if (rd_idx == IdxW'(i)) begin
                    rd_data_q <= (rd_sel == SelBase) ? base_q[i] : result_q[i];
                end
            end
        end
    end

    // Channel enable is held from settle through store of the channel under test.
    always_comb begin
        test_en = '0;
        for (int unsigned i = 0; i < NUM_OSC; i++) begin
            test_en[i] = ((state_q == StSettle) || (state_q == StCount) || (state_q == StStore))
                         && (idx_q == IdxW'(i));
        end
    end

    assign bus.test_en_o = test_en;
    assign bus.stress_o  = (state_q == StIdle);
    assign bus.busy_o    = (state_q != StIdle);
    assign bus.done_o    = (state_q == StDone);
    assign bus.alarm_o   = alarm_q;
    assign bus.rd_data_o = rd_data_q;

endmodule
